// File: rtl/y86_mem_pkg.sv
// ---------------------------------------------------------------------------
// y86_mem_pkg
// Shared definitions for the Y86-64 data-memory path: the responder FSM
// state type, the processor status codes that memory errors feed into,
// and the machine word width.
// ---------------------------------------------------------------------------
package y86_mem_pkg;

   // Machine word width. Every data access moves one full word.
   localparam int WORD_W = 64;

   // Processor status codes. A responder address error turns into SADR
   // in the memory stage.
   localparam logic [3:0] SAOK = 4'b0001;
   localparam logic [3:0] SHLT = 4'b0010;
   localparam logic [3:0] SADR = 4'b0100;
   localparam logic [3:0] SINS = 4'b1000;

   // Responder transaction phases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Byte-addressed storage of MEM_BYTES bytes, exposed as 8-byte little-endian
// words. The byte at the base address sits in bits [7:0]. The byte at
// base+7 sits in bits [63:56]. Contents are never cleared.
//
// Ports:
//   clk      - clock; writes take effect on posedge
//   rd_addr  - byte address of the combinational 8-byte read
//   rd_data  - read word (bytes past the end of storage read as 0)
//   wr_en    - commit wr_data at wr_addr on this posedge
//   wr_addr  - byte address of the 8-byte write
//   wr_data  - write word, little-endian
// ---------------------------------------------------------------------------
module dmem_array
   import y86_mem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = $clog2(MEM_BYTES)
)(
   input  logic              clk,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data
);

   logic [7:0]  mem [MEM_BYTES];
   logic [AW:0] rd_idx [8];
   logic [AW:0] wr_idx [8];

   // Per-byte addresses for both ports. They carry one extra bit so that an
   // access running past the last byte is seen as out of range and does not
   // wrap back to address 0.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         rd_idx[k] = {1'b0, rd_addr} + (AW+1)'(k);
         wr_idx[k] = {1'b0, wr_addr} + (AW+1)'(k);
      end
   end

   // Little-endian word assembly. Bytes beyond the end of storage read as
   // zero. The responder masks those accesses anyway, so this only keeps the
   // array from indexing outside its bounds.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < 8; k++) begin
         if (rd_idx[k] < (AW+1)'(MEM_BYTES)) begin
            rd_data[8*k +: 8] = mem[rd_idx[k][AW-1:0]];
         end
      end
   end

   // Byte-wise write of the whole word. Bytes that fall outside storage are
   // dropped.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 8; k++) begin
            if (wr_idx[k] < (AW+1)'(MEM_BYTES)) begin
               mem[wr_idx[k][AW-1:0]] <= wr_data[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Slave end of the Y86-64 memory-stage data access. It accepts one 8-byte
// read or write per handshake and waits LATENCY cycles. It then pulses
// rsp_valid for one cycle with the read data (zero for writes) and an
// address-error flag.
//
// Parameters:
//   MEM_BYTES - storage size in bytes (multiple of 8)
//   LATENCY   - wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   req_valid / req_ready - request handshake
//   req_write, req_addr, req_wdata - request contents
//   rsp_valid - one-cycle response pulse
//   rsp_rdata, rsp_error - registered response payload
//
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When it is defined, an
// address that is not 8-byte aligned is also reported as an address error.
// ---------------------------------------------------------------------------
module dmem_responder
   import y86_mem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int LATENCY   = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_error
);

   localparam int AW = $clog2(MEM_BYTES);

   dmem_state_t       state, next_state;
   logic [3:0]        count, next_count;

   logic              lat_write;
   logic              lat_error;
   logic [AW-1:0]     lat_addr;
   logic [WORD_W-1:0] lat_wdata;

   logic              accept;
   logic [WORD_W:0]   req_end;
   logic              req_error;
   logic              cur_write;
   logic              cur_error;
   logic [AW-1:0]     cur_addr;
   logic [WORD_W-1:0] cur_wdata;
   logic              enter_resp;
   logic              commit;
   logic [WORD_W-1:0] array_rdata;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   // Address check. The end address is formed in 65 bits, so an access near
   // the top of the 64-bit space is reported as an error and does not wrap
   // onto low memory.
   assign req_end = {1'b0, req_addr} + 65'd8;

   always_comb begin
      req_error = (req_end > 65'(MEM_BYTES));
`ifdef DMEM_MISALIGN_CHECK_EN
      req_error = req_error | (req_addr[2:0] != 3'd0);
`endif
   end

   // Select the transaction that is about to reach RESP. With zero latency
   // RESP follows the accepting edge directly, before the latches hold
   // anything, so in IDLE the live request is used instead.
   always_comb begin
      cur_write = lat_write;
      cur_error = lat_error;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      if (state == IDLE) begin
         cur_write = req_write;
         cur_error = req_error;
         cur_addr  = req_addr[AW-1:0];
         cur_wdata = req_wdata;
      end
   end

   // Next-state and wait-counter logic. WAIT counts down from LATENCY and
   // moves to RESP on the cycle the counter reads 1. RESP always lasts
   // exactly one cycle.
   always_comb begin
      next_state = state;
      next_count = count;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  next_state = RESP;
                  next_count = 4'd0;
               end else begin
                  next_state = WAIT;
                  next_count = 4'(LATENCY);
               end
            end
         end
         WAIT: begin
            next_count = count - 4'd1;
            if (count <= 4'd1) begin
               next_state = RESP;
               next_count = 4'd0;
            end
         end
         RESP: begin
            next_state = IDLE;
            next_count = 4'd0;
         end
         default: begin
            next_state = IDLE;
            next_count = 4'd0;
         end
      endcase
   end

   // The write commits and the read is sampled on the edge that enters RESP.
   // Reset on that same edge abandons the transaction, so the write is
   // blocked as well.
   assign enter_resp = (state != RESP) && (next_state == RESP);
   assign commit     = enter_resp && cur_write && !cur_error && !rst;

   // State register. Reset wins over a simultaneous accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         state <= next_state;
         count <= next_count;
      end
   end

   // Request latches. They are only consulted in WAIT, so they need no
   // reset value.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write <= req_write;
         lat_error <= req_error;
         lat_addr  <= req_addr[AW-1:0];
         lat_wdata <= req_wdata;
      end
   end

   // Registered response payload. It is loaded when RESP is entered and held
   // afterwards. Writes and erroring accesses return zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else if (enter_resp) begin
         rsp_rdata <= (cur_write || cur_error) ? '0 : array_rdata;
         rsp_error <= cur_error;
      end
   end

   dmem_array #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_array (
      .clk     (clk),
      .rd_addr (cur_addr),
      .rd_data (array_rdata),
      .wr_en   (commit),
      .wr_addr (cur_addr),
      .wr_data (cur_wdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. One instance runs with LATENCY=2
// and a second with LATENCY=0. Both have 1024 bytes of storage. Expected
// values come from a byte-array model of each memory plus the address-error
// rule. The optional build macro DMEM_MISALIGN_CHECK_EN is honoured by the
// model as well.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk;
   logic        rst;

   logic        v2, w2, rdy2, rv2, re2;
   logic [63:0] a2, d2, rd2;
   logic        v0, w0, rdy0, rv0, re0;
   logic [63:0] a0, d0, rd0;

   int          n_cmp;
   int          n_fail;

   logic [7:0]  mem_m [0:1][0:1023];

   dmem_responder #(.MEM_BYTES(1024), .LATENCY(2)) dut_l2 (
      .clk(clk), .rst(rst),
      .req_valid(v2), .req_write(w2), .req_addr(a2), .req_wdata(d2),
      .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_error(re2)
   );

   dmem_responder #(.MEM_BYTES(1024), .LATENCY(0)) dut_l0 (
      .clk(clk), .rst(rst),
      .req_valid(v0), .req_write(w0), .req_addr(a0), .req_wdata(d0),
      .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_error(re0)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference address rule. An access is legal only if all eight bytes fit
   // inside the 1024-byte storage.
   function automatic logic model_err(input logic [63:0] a);
      logic [64:0] last_plus_one;
      last_plus_one = {1'b0, a} + 65'd8;
      model_err = (last_plus_one > 65'd1024);
`ifdef DMEM_MISALIGN_CHECK_EN
      if (a[2:0] != 3'd0) model_err = 1'b1;
`endif
   endfunction

   // Apply one transaction to the model and return the response it predicts.
   task automatic model_apply(input int sel, input logic wr, input logic [63:0] a,
                              input logic [63:0] d, output logic [63:0] exp_rd,
                              output logic exp_err);
      exp_err = model_err(a);
      exp_rd  = '0;
      if (!exp_err) begin
         for (int k = 0; k < 8; k++) begin
            if (wr) mem_m[sel][int'(a[9:0]) + k] = d[8*k +: 8];
            else    exp_rd[8*k +: 8] = mem_m[sel][int'(a[9:0]) + k];
         end
      end
   endtask

   // Drive one request on the chosen instance (0 = LATENCY 2, 1 = LATENCY 0).
   // Returns the response and the number of cycles from the accepting edge to
   // the rsp_valid pulse. A timed-out wait returns 99 cycles.
   task automatic do_txn(input int sel, input logic wr, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] rd,
                         output logic err, output int lat);
      int guard;
      @(negedge clk);
      if (sel == 0) begin v2 = 1'b1; w2 = wr; a2 = a; d2 = d; end
      else          begin v0 = 1'b1; w0 = wr; a0 = a; d0 = d; end
      guard = 0;
      while (!((sel == 0) ? rdy2 : rdy0) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      if (sel == 0) v2 = 1'b0; else v0 = 1'b0;
      lat = 1;
      while (!((sel == 0) ? rv2 : rv0) && lat < 99) begin
         @(negedge clk);
         lat++;
      end
      rd  = (sel == 0) ? rd2 : rd0;
      err = (sel == 0) ? re2 : re0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (rdy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready_l2: got %b expected 1", rdy2); end
      n_cmp++; if (rv2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_l2: got %b expected 0", rv2); end
      n_cmp++; if (rd2 !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rdata_l2: got %h expected 0", rd2); end
      n_cmp++; if (re2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_error_l2: got %b expected 0", re2); end
      n_cmp++; if (rdy0 !== 1'b1 || rv0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_l0: ready %b valid %b expected 1/0", rdy0, rv0); end
      rst = 1'b0;
   endtask

   // Give every byte of both memories a known value so that later reads have
   // a defined expectation.
   task automatic test_fill;
      logic [63:0] rd, erd, d;
      logic        err, eerr;
      int          lat;
      for (int sel = 0; sel < 2; sel++) begin
         for (int i = 0; i < 128; i++) begin
            d = {$urandom, $urandom};
            model_apply(sel, 1'b1, 64'(i * 8), d, erd, eerr);
            do_txn(sel, 1'b1, 64'(i * 8), d, rd, err, lat);
            n_cmp++;
            if (err !== eerr || rd !== erd || lat != ((sel == 0) ? 3 : 1)) begin
               n_fail++;
               $display("[TB] FAIL fill[%0d][%0d]: got err %b rd %h lat %0d expected err %b rd %h", sel, i, err, rd, lat, eerr, erd);
            end
         end
      end
   endtask

   task automatic test_basic_rw;
      logic [63:0] rd, erd;
      logic        err, eerr;
      int          lat;
      model_apply(0, 1'b1, 64'h10, 64'h1122334455667788, erd, eerr);
      do_txn(0, 1'b1, 64'h10, 64'h1122334455667788, rd, err, lat);
      n_cmp++; if (lat != 3) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d expected 3", lat); end
      n_cmp++; if (err !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("[TB] FAIL wr_resp: got err %b rd %h expected 0/0", err, rd); end
      do_txn(0, 1'b0, 64'h10, 64'h0, rd, err, lat);
      n_cmp++; if (lat != 3) begin n_fail++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
      n_cmp++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("[TB] FAIL rd_data: got %h expected 1122334455667788", rd); end
      n_cmp++; if (rd[7:0] !== 8'h88) begin n_fail++; $display("[TB] FAIL low_byte: got %h expected 88", rd[7:0]); end
      model_apply(0, 1'b0, 64'h0F, 64'h0, erd, eerr);
      do_txn(0, 1'b0, 64'h0F, 64'h0, rd, err, lat);
      n_cmp++; if (rd !== erd || err !== eerr) begin n_fail++; $display("[TB] FAIL rd_0F: got %h/%b expected %h/%b", rd, err, erd, eerr); end
   endtask

   task automatic test_boundary;
      logic [63:0] rd, erd, keep;
      logic        err, eerr;
      int          lat;
      model_apply(0, 1'b0, 64'h3F8, 64'h0, keep, eerr);
      do_txn(0, 1'b0, 64'h3F8, 64'h0, rd, err, lat);
      n_cmp++; if (err !== 1'b0 || rd !== keep) begin n_fail++; $display("[TB] FAIL rd_3F8: got %h/%b expected %h/0", rd, err, keep); end
      do_txn(0, 1'b0, 64'h3F9, 64'h0, rd, err, lat);
      n_cmp++; if (err !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("[TB] FAIL rd_3F9: got %h/%b expected 0/1", rd, err); end
      model_apply(0, 1'b1, 64'h3FC, 64'hDEADBEEFCAFEF00D, erd, eerr);
      do_txn(0, 1'b1, 64'h3FC, 64'hDEADBEEFCAFEF00D, rd, err, lat);
      n_cmp++; if (err !== 1'b1 || lat != 3) begin n_fail++; $display("[TB] FAIL wr_3FC: got err %b lat %0d expected 1/3", err, lat); end
      do_txn(0, 1'b0, 64'h3F8, 64'h0, rd, err, lat);
      n_cmp++; if (rd !== keep) begin n_fail++; $display("[TB] FAIL rd_3F8_after: got %h expected %h", rd, keep); end
   endtask

   task automatic test_wrap;
      logic [63:0] rd;
      logic        err;
      int          lat;
      do_txn(0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, rd, err, lat);
      n_cmp++; if (err !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("[TB] FAIL wrap_FC: got %h/%b expected 0/1", rd, err); end
      do_txn(1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, rd, err, lat);
      n_cmp++; if (err !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("[TB] FAIL wrap_F8: got %h/%b expected 0/1", rd, err); end
   endtask

   task automatic test_reset_mid;
      logic [63:0] rd, erd, before20, before30;
      logic        err, eerr;
      int          lat, pulses;
      model_apply(0, 1'b0, 64'h20, 64'h0, before20, eerr);
      model_apply(0, 1'b0, 64'h30, 64'h0, before30, eerr);
      // Write accepted, then reset while it sits in WAIT.
      @(negedge clk);
      v2 = 1'b1; w2 = 1'b1; a2 = 64'h20; d2 = 64'hAAAAAAAAAAAAAAAA;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (rdy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL midwait_ready: got %b expected 1", rdy2); end
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (rv2) pulses++;
         @(negedge clk);
      end
      n_cmp++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL midwait_pulses: got %0d expected 0", pulses); end
      do_txn(0, 1'b0, 64'h20, 64'h0, rd, err, lat);
      n_cmp++; if (rd !== before20) begin n_fail++; $display("[TB] FAIL midwait_read: got %h expected %h", rd, before20); end
      // Reset on the same edge as an accept: the request is dropped.
      @(negedge clk);
      v2 = 1'b1; w2 = 1'b1; a2 = 64'h30; d2 = 64'h5555555555555555; rst = 1'b1;
      @(negedge clk);
      v2 = 1'b0; rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (rv2) pulses++;
         @(negedge clk);
      end
      n_cmp++; if (pulses != 0 || rdy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_accept: got pulses %0d ready %b expected 0/1", pulses, rdy2); end
      do_txn(0, 1'b0, 64'h30, 64'h0, rd, err, lat);
      n_cmp++; if (rd !== before30) begin n_fail++; $display("[TB] FAIL rst_accept_read: got %h expected %h", rd, before30); end
      // Reset during RESP: the write has already committed and must stay.
      @(negedge clk);
      v2 = 1'b1; w2 = 1'b1; a2 = 64'h28; d2 = 64'h0123456789ABCDEF;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      lat = 1;
      while (!rv2 && lat < 20) begin @(negedge clk); lat++; end
      model_apply(0, 1'b1, 64'h28, 64'h0123456789ABCDEF, erd, eerr);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (rdy2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 64'h0) begin n_fail++; $display("[TB] FAIL inresp_reset: got ready %b valid %b rd %h expected 1/0/0", rdy2, rv2, rd2); end
      model_apply(0, 1'b0, 64'h28, 64'h0, erd, eerr);
      do_txn(0, 1'b0, 64'h28, 64'h0, rd, err, lat);
      n_cmp++; if (rd !== erd) begin n_fail++; $display("[TB] FAIL inresp_read: got %h expected %h", rd, erd); end
   endtask

   // Continuous req_valid on the zero-latency instance. Each accept should
   // be followed by one busy cycle carrying the response.
   task automatic test_back_to_back;
      logic [64:0] q [$];
      logic [64:0] exp_pair;
      logic [63:0] erd, a, d;
      logic        eerr, wr, acc_prev;
      int          accepts, resps;
      accepts = 0; resps = 0; acc_prev = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 60; c++) begin
         n_cmp++;
         if (rdy0 !== !acc_prev || rv0 !== acc_prev) begin
            n_fail++;
            $display("[TB] FAIL b2b_spacing[%0d]: got ready %b valid %b expected %b/%b", c, rdy0, rv0, !acc_prev, acc_prev);
         end
         if (rv0) begin
            resps++;
            n_cmp++;
            if (q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL b2b_extra_rsp[%0d]: got response expected none", c);
            end else begin
               exp_pair = q.pop_front();
               if ({re0, rd0} !== exp_pair) begin
                  n_fail++;
                  $display("[TB] FAIL b2b_data[%0d]: got %b/%h expected %b/%h", c, re0, rd0, exp_pair[64], exp_pair[63:0]);
               end
            end
         end
         acc_prev = 1'b0;
         if (rdy0) begin
            if (accepts < 25) begin
               wr = 1'($urandom_range(0, 1));
               a  = 64'($urandom_range(0, 1023));
               d  = {$urandom, $urandom};
               v0 = 1'b1; w0 = wr; a0 = a; d0 = d;
               model_apply(1, wr, a, d, erd, eerr);
               q.push_back({eerr, erd});
               accepts++;
               acc_prev = 1'b1;
            end else begin
               v0 = 1'b0;
            end
         end
         @(negedge clk);
      end
      v0 = 1'b0;
      n_cmp++;
      if (resps != 25 || q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_count: got %0d responses expected 25", resps);
      end
   endtask

   task automatic test_misalign;
      logic [63:0] rd, erd;
      logic        err, eerr;
      int          lat;
      model_apply(0, 1'b1, 64'h13, 64'hFEDCBA9876543210, erd, eerr);
      do_txn(0, 1'b1, 64'h13, 64'hFEDCBA9876543210, rd, err, lat);
      n_cmp++; if (err !== eerr) begin n_fail++; $display("[TB] FAIL misalign_wr: got %b expected %b", err, eerr); end
      model_apply(0, 1'b0, 64'h13, 64'h0, erd, eerr);
      do_txn(0, 1'b0, 64'h13, 64'h0, rd, err, lat);
      n_cmp++; if (rd !== erd || err !== eerr) begin n_fail++; $display("[TB] FAIL misalign_rd: got %h/%b expected %h/%b", rd, err, erd, eerr); end
   endtask

   // Random mixed traffic on the LATENCY=2 instance.
   task automatic test_random;
      logic [63:0] rd, erd, a, d;
      logic        err, eerr, wr;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
         d  = {$urandom, $urandom};
         model_apply(0, wr, a, d, erd, eerr);
         do_txn(0, wr, a, d, rd, err, lat);
         n_cmp++;
         if (rd !== erd || err !== eerr || lat != 3) begin
            n_fail++;
            $display("[TB] FAIL random[%0d]: got %h/%b lat %0d expected %h/%b lat 3", i, rd, err, lat, erd, eerr);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1;
      v2 = 1'b0; w2 = 1'b0; a2 = '0; d2 = '0;
      v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
      test_reset;
      test_fill;
      test_basic_rw;
      test_boundary;
      test_wrap;
      test_reset_mid;
      test_back_to_back;
      test_misalign;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the Y86-64 pipeline: the slave end of the memory-stage data access.
- Accepts one 8-byte read or write request per handshake and waits a programmable number of cycles.
- Returns read data, or a write acknowledge, together with an address-error flag that the memory stage maps to the SADR status.
- Replaces the zero-latency combinational data memory, so that pipeline stall logic can be exercised against a slow memory.

Parameters:
MEM_BYTES, 1024, size of the byte-addressed storage; must be a multiple of 8.
LATENCY, 2, wait cycles between request acceptance and response (0..15).

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_write  input  1  1 = write, 0 = read
req_addr  input  64  byte address of the 8-byte access
req_wdata  input  64  write data, little-endian
req_ready  output  1  responder can accept a request this cycle
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  64  read data, valid with rsp_valid
rsp_error  output  1  address error, valid with rsp_valid

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, wait counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - Storage contents are NOT cleared.
- Acceptance: on a posedge with req_valid && req_ready, latch write, addr, wdata and the error flag.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept: go to WAIT with counter=LATENCY if LATENCY>0; go straight to RESP if LATENCY=0.
  - WAIT: req_ready=0. Counter decrements each cycle; on the cycle counter==1 the next state is RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: rsp_valid is high in the (LATENCY+1)-th cycle after the accepting edge. Max throughput is one request per LATENCY+2 cycles.
- Requests presented while req_ready=0 are ignored. The requester must hold them until accepted.
- Error rule: error = (req_addr + 8 > MEM_BYTES).
  - Computed in 65 bits, so address wrap near 2^64 is an error, not an alias.
  - On error: no storage update, rsp_rdata=0, rsp_error=1.
- Data layout: byte at addr is bits [7:0], byte at addr+7 is bits [63:56].
- Write commit:
  - Storage is written at the edge that enters RESP, never earlier.
  - Write response has rsp_rdata=0 and rsp_error as computed.
- Read sampling:
  - Read data is sampled at the edge that enters RESP.
  - Because writes never overlap reads, a read always returns the latest committed write.
- rsp_rdata and rsp_error are registered. They hold their value outside RESP, but are meaningful only when rsp_valid=1.
- Reset mid-operation (in WAIT or RESP): the pending transaction is abandoned and any uncommitted write is discarded. An already-committed write remains.
- rst has priority over a simultaneous accept.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: req_addr[2:0] != 0 also sets the error (no write, rdata=0).
- Undefined: unaligned 8-byte accesses are legal and byte-exact.

Decomposition:
- Shared package y86_mem_pkg holds:
  - FSM state enum (IDLE/WAIT/RESP).
  - Status constants SAOK=4'b0001, SHLT=4'b0010, SADR=4'b0100, SINS=4'b1000.
  - Word width constant 64.
- One sub-module, dmem_array: MEM_BYTES byte storage with a single 8-byte little-endian read port and a write-enabled 8-byte write port. The responder owns the FSM, counter and error logic.

Test Plan:
1. LATENCY=2: write 0x1122334455667788 @0x10, then read @0x10 → rsp_valid exactly 3 cycles after each accept; rdata=0x1122334455667788; byte @0x10 = 0x88.
2. Read @0x3F8 with MEM_BYTES=1024 → error=0. Read @0x3F9 → rsp_error=1, rdata=0. Write @0x3FC → error=1, and a following read @0x3F8 is unchanged.
3. Read @0xFFFFFFFFFFFFFFFC → rsp_error=1 (65-bit wrap check).
4. Accept a write 0xAA.. @0x20, assert rst during WAIT → rsp_valid never pulses, req_ready=1 after reset; read @0x20 returns the prior value.
5. Hold req_valid continuously with LATENCY=0 → accepts spaced 2 cycles apart, req_ready=0 while busy, one rsp_valid per accept.
6. Write @0x13 with DMEM_MISALIGN_CHECK_EN defined → rsp_error=1. Same write without the macro → error=0, and read-back @0x13 matches.
